axi_arbiter_mtos_mn: RTL and testbench

AXI_ARBITER_MTOS_MN -- requirements
Module: axi_arbiter_mtos_mn

---
 rtl/axi_arbiter_defines.sv | 52 +++++
 rtl/axi_arbiter_fifo_sync.sv | 47 ++++
 rtl/axi_arbiter_mtos_mn.sv | 212 +++++++++++++++++++++
 tb/tb_axi_arbiter_mtos_mn.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arbiter_defines.sv
// Shared definitions for the AXI many-to-one arbiter:
// FSM states, arbitration modes and selection helpers.
package axi_arbiter_defines;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOCK = 2'd2
  } arb_st_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Search starts at ptr and wraps modulo num; ptr=0 gives fixed priority.
  function automatic logic [15:0] rr_sel(
    input logic [15:0] req,
    input logic [3:0]  ptr,
    input logic [4:0]  num
  );
    logic [15:0] g;
    logic        hit;
    logic [4:0]  idx;
    g   = '0;
    hit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = ({1'b0, ptr} + 5'(k)) % num;
      if ((5'(k) < num) && !hit && req[idx[3:0]]) begin
        g[idx[3:0]] = 1'b1;
        hit         = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (oh[k]) r = r | 4'(k);
    end
    return r;
  endfunction

  function automatic logic [3:0] ptr_next(
    input logic [3:0] idx,
    input logic [4:0] num
  );
    if (({1'b0, idx} + 5'd1) >= num) return 4'd0;
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/axi_arbiter_fifo_sync.sv
// Synchronous-reset FIFO holding the write-address order
// so write data is granted in the same master sequence.
module axi_arbiter_fifo_sync #(
  parameter int FDW = 8,
  parameter int FAW = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_wr_en,
  input  logic [FDW-1:0] i_wr_data,
  input  logic           i_rd_en,
  output logic [FDW-1:0] o_rd_data,
  output logic           o_full,
  output logic           o_empty
);

  localparam int DEPTH = 1 << FAW;

  logic [FDW-1:0] r_mem [DEPTH];
  logic [FAW:0]   r_wptr;
  logic [FAW:0]   r_rptr;
  logic           w_we;
  logic           w_re;

  assign w_we = i_wr_en & ~o_full;
  assign w_re = i_rd_en & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + 1'b1;
      if (w_re) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[r_wptr[FAW-1:0]] <= i_wr_data;
  end

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[FAW] != r_rptr[FAW]) &&
                     (r_wptr[FAW-1:0] == r_rptr[FAW-1:0]);
  assign o_rd_data = r_mem[r_rptr[FAW-1:0]];

endmodule

// File: rtl/axi_arbiter_mtos_mn.sv
// Many-master to one-slave AXI arbiter: AR/AW grant FSMs with
// exclusive-lock handling and a write-order FIFO driving W grants.
module axi_arbiter_mtos_mn
  import axi_arbiter_defines::*;
#(
  parameter int WIDTH_CID = 4,
  parameter int WIDTH_ID  = 4,
  parameter int WIDTH_SID = WIDTH_CID + WIDTH_ID,
  parameter int NUM       = 4,
  parameter int MODE      = 0,
  parameter int FAW       = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [NUM-1:0]           AWSELECT,
  input  logic [NUM-1:0]           AWVALID,
  input  logic [NUM-1:0]           AWREADY,
  input  logic [NUM-1:0]           AWLOCK,
  output logic [NUM-1:0]           AWGRANT,
  input  logic [NUM*WIDTH_SID-1:0] AWSID,
  input  logic [NUM-1:0]           WVALID,
  input  logic [NUM-1:0]           WLAST,
  input  logic [NUM-1:0]           WREADY,
  output logic [NUM-1:0]           WGRANT,
  input  logic [NUM-1:0]           ARSELECT,
  input  logic [NUM-1:0]           ARVALID,
  input  logic [NUM-1:0]           ARREADY,
  input  logic [NUM-1:0]           ARLOCK,
  output logic [NUM-1:0]           ARGRANT,
  input  logic [NUM*WIDTH_SID-1:0] ARSID,
  input  logic [NUM*WIDTH_CID-1:0] MID
);

  localparam logic [4:0] LP_NUM = 5'(NUM);
  localparam int         TW     = WIDTH_SID - WIDTH_CID;

  arb_st_e              r_ar_st;
  arb_st_e              r_aw_st;
  logic [NUM-1:0]       r_ar_grant;
  logic [NUM-1:0]       r_aw_grant;
  logic [3:0]           r_ar_ptr;
  logic [3:0]           r_aw_ptr;
  logic                 r_locked;
  logic                 r_unlock;
  logic [WIDTH_SID-1:0] r_locksid;

  logic [NUM-1:0]       w_ar_sel;
  logic [NUM-1:0]       w_aw_sel;
  logic [NUM-1:0]       w_lk_hit;
  logic [NUM-1:0]       w_lk_sel;
  logic [3:0]           w_ar_base;
  logic [3:0]           w_aw_base;
  logic [WIDTH_CID-1:0] w_lk_cid;
  logic [WIDTH_SID-1:0] w_ar_gsid;
  logic [WIDTH_SID-1:0] w_aw_gsid;
  logic [WIDTH_SID-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_ar_hs;
  logic                 w_aw_hs;
  logic                 w_pop;
  logic                 w_aw_comb;
  logic                 w_unused;

  assign w_ar_base = (MODE == MODE_RR) ? r_ar_ptr : 4'd0;
  assign w_aw_base = (MODE == MODE_RR) ? r_aw_ptr : 4'd0;

  assign w_ar_sel = NUM'(rr_sel(16'(ARSELECT & ARVALID),
                                w_ar_base, LP_NUM));
  assign w_aw_sel = NUM'(rr_sel(16'(AWSELECT & AWVALID),
                                w_aw_base, LP_NUM));

  assign w_lk_cid = r_locksid[WIDTH_SID-1 -: WIDTH_CID];
  assign w_unused = ^{r_locksid[TW-1:0], w_head[TW-1:0]};

  always_comb begin
    w_lk_hit = '0;
    for (int i = 0; i < NUM; i++) begin
      w_lk_hit[i] = AWSELECT[i] && AWVALID[i] &&
        (MID[i*WIDTH_CID +: WIDTH_CID] == w_lk_cid) &&
        (AWSID[i*WIDTH_SID+TW +: WIDTH_CID] == w_lk_cid);
    end
  end

  assign w_lk_sel = NUM'(rr_sel(16'(w_lk_hit), 4'd0, LP_NUM));

  assign ARGRANT   = (r_ar_st == ST_RUN) ? w_ar_sel : r_ar_grant;
  assign w_aw_comb = (r_aw_st == ST_RUN) && !r_locked && !w_full;
  assign AWGRANT   = w_aw_comb ? w_aw_sel : r_aw_grant;

  assign w_ar_hs = |(ARGRANT & ARVALID & ARREADY);
  assign w_aw_hs = |(AWGRANT & AWVALID & AWREADY);
  assign w_pop   = |(WGRANT & WVALID & WREADY & WLAST);

  always_comb begin
    w_ar_gsid = '0;
    w_aw_gsid = '0;
    for (int i = 0; i < NUM; i++) begin
      if (w_ar_sel[i])
        w_ar_gsid |= ARSID[i*WIDTH_SID +: WIDTH_SID];
      if (AWGRANT[i])
        w_aw_gsid |= AWSID[i*WIDTH_SID +: WIDTH_SID];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_ar_st    <= ST_RUN;
      r_ar_grant <= '0;
      r_ar_ptr   <= '0;
      r_locked   <= 1'b0;
      r_locksid  <= '0;
    end else begin
      if (w_ar_hs)
        r_ar_ptr <= ptr_next(oh2idx(16'(ARGRANT)), LP_NUM);
      unique case (r_ar_st)
        ST_RUN: begin
          if (|(w_ar_sel & ARLOCK)) begin
            r_locked   <= 1'b1;
            r_locksid  <= w_ar_gsid;
            r_ar_grant <= w_ar_sel;
            r_ar_st    <= ST_LOCK;
          end else if (|w_ar_sel && !(|(w_ar_sel & ARREADY))) begin
            r_ar_grant <= w_ar_sel;
            r_ar_st    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ar_hs) begin
            r_ar_grant <= '0;
            r_ar_st    <= ST_RUN;
          end
        end
        ST_LOCK: begin
          if (r_unlock) begin
            r_locked   <= 1'b0;
            r_locksid  <= '0;
            r_ar_grant <= '0;
            r_ar_st    <= ST_RUN;
          end
        end
        default: r_ar_st <= ST_RUN;
      endcase
    end
  end

  // While locked only the lock owner's write may proceed.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_aw_st    <= ST_RUN;
      r_aw_grant <= '0;
      r_aw_ptr   <= '0;
      r_unlock   <= 1'b0;
    end else begin
      if (w_aw_hs)
        r_aw_ptr <= ptr_next(oh2idx(16'(AWGRANT)), LP_NUM);
      unique case (r_aw_st)
        ST_RUN: begin
          if (!r_locked) begin
            if (!w_full && |w_aw_sel &&
                !(|(w_aw_sel & AWREADY))) begin
              r_aw_grant <= w_aw_sel;
              r_aw_st    <= ST_WAIT;
            end
          end else if (!w_full && |w_lk_sel) begin
            r_aw_grant <= w_lk_sel;
            r_unlock   <= ~|(w_lk_sel & AWLOCK);
            r_aw_st    <= ST_LOCK;
          end
        end
        ST_WAIT: begin
          if (w_aw_hs) begin
            r_aw_grant <= '0;
            r_aw_st    <= ST_RUN;
          end
        end
        ST_LOCK: begin
          if (w_aw_hs) begin
            r_aw_grant <= '0;
            r_unlock   <= 1'b0;
            r_aw_st    <= ST_RUN;
          end
        end
        default: r_aw_st <= ST_RUN;
      endcase
    end
  end

  axi_arbiter_fifo_sync #(
    .FDW (WIDTH_SID),
    .FAW (FAW)
  ) u_fifo (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETn),
    .i_wr_en   (w_aw_hs),
    .i_wr_data (w_aw_gsid),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    WGRANT = '0;
    for (int i = 0; i < NUM; i++) begin
      WGRANT[i] = !w_empty &&
        (MID[i*WIDTH_CID +: WIDTH_CID] ==
         w_head[WIDTH_SID-1 -: WIDTH_CID]);
    end
  end

endmodule

// File: tb/tb_axi_arbiter_mtos_mn.sv
// Bench for axi_arbiter_mtos_mn: fixed-priority/FAW=2 instance
// plus a round-robin instance sharing the same stimulus.
module tb_axi_arbiter_mtos_mn;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  AWSELECT, AWVALID, AWREADY, AWLOCK;
  logic [3:0]  WVALID, WLAST, WREADY;
  logic [3:0]  ARSELECT, ARVALID, ARREADY, ARLOCK;
  logic [31:0] AWSID, ARSID;
  logic [15:0] MID;
  logic [3:0]  aw_g0, w_g0, ar_g0;
  logic [3:0]  aw_g1, w_g1, ar_g1;

  int errs;
  int checks;
  logic [3:0] q_exp[$];
  logic [3:0] exp_g;

  axi_arbiter_mtos_mn #(.MODE(0), .FAW(2)) u_dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWSELECT(AWSELECT), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .AWLOCK(AWLOCK),
    .AWGRANT(aw_g0), .AWSID(AWSID),
    .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .WGRANT(w_g0),
    .ARSELECT(ARSELECT), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .ARLOCK(ARLOCK),
    .ARGRANT(ar_g0), .ARSID(ARSID), .MID(MID)
  );

  axi_arbiter_mtos_mn #(.MODE(1), .FAW(4)) u_dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWSELECT(AWSELECT), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .AWLOCK(AWLOCK),
    .AWGRANT(aw_g1), .AWSID(AWSID),
    .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .WGRANT(w_g1),
    .ARSELECT(ARSELECT), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .ARLOCK(ARLOCK),
    .ARGRANT(ar_g1), .ARSID(ARSID), .MID(MID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle();
    AWSELECT = '0; AWVALID = '0; AWREADY = '0; AWLOCK = '0;
    WVALID = '0; WLAST = '0; WREADY = '0;
    ARSELECT = '0; ARVALID = '0; ARREADY = '0; ARLOCK = '0;
    AWSID = 32'h3020_1000; ARSID = 32'h3020_1000;
    MID = 16'h3210;
  endtask

  task automatic do_reset();
    idle();
    ARESETn = 1'b0;
    step();
    step();
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    ARESETn = 1'b0;
    step();
    step();
    @(negedge ACLK);
    checks++;
    if ({aw_g0, w_g0, ar_g0} !== 12'h000) begin
      errs++;
      $display("FAIL rst_dut0: got %h want 000", {aw_g0, w_g0, ar_g0});
    end
    checks++;
    if ({aw_g1, w_g1, ar_g1} !== 12'h000) begin
      errs++;
      $display("FAIL rst_dut1: got %h want 000", {aw_g1, w_g1, ar_g1});
    end
    step();
    ARESETn = 1'b1;
    ARSELECT = 4'b0100; ARVALID = 4'b0100; ARREADY = 4'b1111;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0100) begin
      errs++;
      $display("FAIL rst_comb0: got %b want 0100", ar_g0);
    end
    checks++;
    if (ar_g1 !== 4'b0100) begin
      errs++;
      $display("FAIL rst_comb1: got %b want 0100", ar_g1);
    end
    step();
  endtask

  task automatic test_fixed();
    do_reset();
    ARSELECT = 4'b1010; ARVALID = 4'b1010; ARREADY = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      checks++;
      if (ar_g0 !== 4'b0010) begin
        errs++;
        $display("FAIL fixed_pri[%0d]: got %b want 0010", k, ar_g0);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ARSELECT = 4'b1111; ARVALID = 4'b1111; ARREADY = 4'b1111;
    for (int k = 0; k < 8; k++) q_exp.push_back(4'(1 << (k % 4)));
    for (int k = 0; k < 8; k++) begin
      @(negedge ACLK);
      exp_g = q_exp.pop_front();
      checks++;
      if (ar_g1 !== exp_g) begin
        errs++;
        $display("FAIL rr[%0d]: got %b want %b", k, ar_g1, exp_g);
      end
      step();
    end
  endtask

  task automatic test_wait();
    do_reset();
    ARSELECT = 4'b0100; ARVALID = 4'b0100; ARREADY = 4'b0000;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0100) begin
      errs++;
      $display("FAIL wait_first: got %b want 0100", ar_g0);
    end
    step();
    ARSELECT = 4'b0101; ARVALID = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      checks++;
      if (ar_g0 !== 4'b0100) begin
        errs++;
        $display("FAIL wait_hold[%0d]: got %b want 0100", k, ar_g0);
      end
      step();
    end
    ARREADY = 4'b0100;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0100) begin
      errs++;
      $display("FAIL wait_hs: got %b want 0100", ar_g0);
    end
    step();
    ARSELECT = 4'b0001; ARVALID = 4'b0001; ARREADY = 4'b0001;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0001) begin
      errs++;
      $display("FAIL wait_next: got %b want 0001", ar_g0);
    end
    step();
  endtask

  task automatic test_lock();
    do_reset();
    ARSELECT = 4'b0010; ARVALID = 4'b0010; ARLOCK = 4'b0010;
    ARREADY = 4'b1111; ARSID[15:8] = 8'h15;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0010) begin
      errs++;
      $display("FAIL lock_ar: got %b want 0010", ar_g0);
    end
    step();
    ARSELECT = 4'b0001; ARVALID = 4'b0001; ARLOCK = 4'b0000;
    AWSELECT = 4'b1000; AWVALID = 4'b1000; AWREADY = 4'b1111;
    AWSID[31:24] = 8'h33;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0010) begin
      errs++;
      $display("FAIL lock_ar_held: got %b want 0010", ar_g0);
    end
    checks++;
    if (aw_g0 !== 4'b0000) begin
      errs++;
      $display("FAIL lock_aw_block: got %b want 0000", aw_g0);
    end
    step();
    AWSELECT = 4'b1010; AWVALID = 4'b1010; AWLOCK = 4'b0000;
    AWSID[15:8] = 8'h17;
    @(negedge ACLK);
    checks++;
    if (aw_g0 !== 4'b0000) begin
      errs++;
      $display("FAIL lock_aw_reg: got %b want 0000", aw_g0);
    end
    step();
    @(negedge ACLK);
    checks++;
    if (aw_g0 !== 4'b0010) begin
      errs++;
      $display("FAIL lock_aw_owner: got %b want 0010", aw_g0);
    end
    checks++;
    if (ar_g0 !== 4'b0010) begin
      errs++;
      $display("FAIL lock_ar_still: got %b want 0010", ar_g0);
    end
    step();
    AWSELECT = 4'b1000; AWVALID = 4'b1000;
    @(negedge ACLK);
    checks++;
    if (ar_g0 !== 4'b0001) begin
      errs++;
      $display("FAIL lock_ar_run: got %b want 0001", ar_g0);
    end
    checks++;
    if (aw_g0 !== 4'b1000) begin
      errs++;
      $display("FAIL lock_aw_m3: got %b want 1000", aw_g0);
    end
    step();
  endtask

  task automatic test_full();
    do_reset();
    AWSELECT = 4'b0001; AWVALID = 4'b0001; AWREADY = 4'b1111;
    AWSID[7:0] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      checks++;
      if (aw_g0 !== 4'b0001) begin
        errs++;
        $display("FAIL full_fill[%0d]: got %b want 0001", k, aw_g0);
      end
      step();
    end
    WVALID = 4'b0001; WLAST = 4'b0001; WREADY = 4'b0001;
    @(negedge ACLK);
    checks++;
    if (aw_g0 !== 4'b0000) begin
      errs++;
      $display("FAIL full_block: got %b want 0000", aw_g0);
    end
    checks++;
    if (w_g0 !== 4'b0001) begin
      errs++;
      $display("FAIL full_w: got %b want 0001", w_g0);
    end
    step();
    WVALID = '0; WLAST = '0;
    @(negedge ACLK);
    checks++;
    if (aw_g0 !== 4'b0001) begin
      errs++;
      $display("FAIL full_reassert: got %b want 0001", aw_g0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    q_exp.delete();
    AWSELECT = 4'b1000; AWVALID = 4'b1000; AWREADY = 4'b1111;
    AWSID[31:24] = 8'h32;
    @(negedge ACLK);
    checks++;
    if (aw_g0 !== 4'b1000) begin
      errs++;
      $display("FAIL ord_aw3: got %b want 1000", aw_g0);
    end
    checks++;
    if (w_g0 !== 4'b0000) begin
      errs++;
      $display("FAIL ord_w_empty: got %b want 0000", w_g0);
    end
    q_exp.push_back(4'b1000);
    step();
    AWSELECT = 4'b0001; AWVALID = 4'b0001; AWSID[7:0] = 8'h04;
    @(negedge ACLK);
    checks++;
    if (aw_g0 !== 4'b0001) begin
      errs++;
      $display("FAIL ord_aw0: got %b want 0001", aw_g0);
    end
    checks++;
    if (w_g0 !== q_exp[0]) begin
      errs++;
      $display("FAIL ord_w_lat: got %b want %b", w_g0, q_exp[0]);
    end
    q_exp.push_back(4'b0001);
    step();
    AWSELECT = '0; AWVALID = '0;
    WVALID = 4'b1000; WREADY = 4'b1111; WLAST = 4'b0000;
    @(negedge ACLK);
    checks++;
    if (w_g0 !== q_exp[0]) begin
      errs++;
      $display("FAIL ord_w_beat: got %b want %b", w_g0, q_exp[0]);
    end
    step();
    WLAST = 4'b1000;
    @(negedge ACLK);
    exp_g = q_exp.pop_front();
    checks++;
    if (w_g0 !== exp_g) begin
      errs++;
      $display("FAIL ord_w_last3: got %b want %b", w_g0, exp_g);
    end
    step();
    WVALID = 4'b0001; WLAST = 4'b0000;
    @(negedge ACLK);
    checks++;
    if (w_g0 !== q_exp[0]) begin
      errs++;
      $display("FAIL ord_w_m0: got %b want %b", w_g0, q_exp[0]);
    end
    step();
    ARESETn = 1'b0;
    step();
    @(negedge ACLK);
    checks++;
    if ({aw_g0, w_g0, ar_g0} !== 12'h000) begin
      errs++;
      $display("FAIL ord_rst: got %h want 000", {aw_g0, w_g0, ar_g0});
    end
    ARESETn = 1'b1;
    step();
    @(negedge ACLK);
    checks++;
    if (w_g0 !== 4'b0000) begin
      errs++;
      $display("FAIL ord_post_rst: got %b want 0000", w_g0);
    end
    q_exp.delete();
    step();
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    ARESETn = 1'b0;
    idle();
    test_reset();
    test_fixed();
    test_round_robin();
    test_wait();
    test_lock();
    test_full();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
